fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 67 ++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with one-word hold buffer, redirect flush and a fixed-size memory read port
module fetch_unit #(
  parameter logic [31:0] START_PC = 32'h80020000,
  parameter logic [1:0]  SZ_WORD  = 2'b10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        mem_busy,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_access_size,
  output logic        mem_rd_wr,
  output logic        mem_enable,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  output logic        insn_valid
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [31:0] pc, req_pc, hold_insn, hold_pc;
  logic req_pending, hold_valid, issue;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = RUN;
  end
  assign insn_valid      = (hold_valid | req_pending) & ~redirect;
  assign issue           = (state == RUN) & ~redirect & ~mem_busy & ~(insn_valid & stall);
  assign mem_enable      = issue;
  assign mem_addr        = pc;
  assign mem_rd_wr       = 1'b1;
  assign mem_access_size = SZ_WORD;
  assign insn            = !insn_valid ? 32'h0 : hold_valid ? hold_insn : mem_rdata;
  assign insn_pc         = hold_valid ? hold_pc : req_pc;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= START_PC;
      req_pc      <= START_PC;
      req_pending <= 1'b0;
      hold_valid  <= 1'b0;
      hold_insn   <= 32'h0;
      hold_pc     <= 32'h0;
    end else if (redirect) begin
      pc          <= {redirect_pc[31:2], 2'b00};
      req_pending <= 1'b0;
      hold_valid  <= 1'b0;
    end else begin
      req_pending <= issue;
      if (issue) begin
        req_pc <= pc;
        pc     <= pc + 32'd4;
      end
      if (req_pending && stall) begin
        hold_valid <= 1'b1;
        hold_insn  <= mem_rdata;
        hold_pc    <= req_pc;
      end else if (hold_valid && !stall) begin
        hold_valid <= 1'b0;
      end
    end
  end
endmodule
